// File: rtl/pmod_spi_master.sv
// Single-clock SPI master for Pmod peripherals: one SS-framed transaction of NBYTES
// full-duplex bytes per request, SCLK stepped by a clock-enable tick, all four SPI modes.
module pmod_spi_master #(
  parameter int CLK_DIV  = 750,
  parameter int NBYTES   = 5,
  parameter bit CPOL     = 1'b0,
  parameter bit CPHA     = 1'b0,
  parameter int SS_LEAD  = 1,
  parameter int BYTE_GAP = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                sndRec,
  input  logic [8*NBYTES-1:0] DIN,
  input  logic                MISO,
  output logic                SS,
  output logic                SCLK,
  output logic                MOSI,
  output logic                BUSY,
  output logic                DONE,
  output logic [8*NBYTES-1:0] DOUT
);
  localparam int W    = 8 * NBYTES;
  localparam int DW   = $clog2(CLK_DIV);
  localparam int HMAX = (SS_LEAD > 16) ? ((SS_LEAD > BYTE_GAP) ? SS_LEAD : BYTE_GAP)
                                       : ((BYTE_GAP > 16) ? BYTE_GAP : 16);
  localparam int HW   = $clog2(HMAX + 1);
  localparam int BW   = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_GAP, S_TRAIL, S_DONE} state_t;
  state_t state_reg, state_next;

  logic [DW-1:0] div_cnt_reg;
  logic [HW-1:0] hcnt_reg;
  logic [BW-1:0] byte_idx_reg;
  logic [W-1:0]  tx_rest_reg;
  logic [7:0]    tx_byte_reg;
  logic [7:0]    rx_byte_reg;
  logic [W-1:0]  rx_buf_reg;
  logic [W-1:0]  dout_reg;
  logic          ss_reg, sclk_reg, mosi_reg, busy_reg, done_reg;

  logic          tick, phase_last, accept, frame_next;
  logic          lead_edge, trail_edge, byte_end;
  logic [7:0]    rx_sampled, rx_complete;
  logic [W+7:0]  rx_cat;

  assign tick       = (state_reg != S_IDLE) && (state_reg != S_DONE) &&
                      (div_cnt_reg == DW'(CLK_DIV - 1));
  assign accept     = (state_reg == S_IDLE) && sndRec;
  assign frame_next = (state_next == S_LEAD) || (state_next == S_XFER) ||
                      (state_next == S_GAP)  || (state_next == S_TRAIL);
  // Even half-period index inside a byte is the leading SCLK edge, odd is trailing.
  assign lead_edge  = (state_reg == S_XFER) && tick && !hcnt_reg[0];
  assign trail_edge = (state_reg == S_XFER) && tick &&  hcnt_reg[0];
  assign byte_end   = (state_reg == S_XFER) && tick && phase_last;

  // With CPHA=1 the final bit is sampled on the very tick that closes the byte.
  assign rx_sampled  = {rx_byte_reg[6:0], MISO};
  assign rx_complete = CPHA ? rx_sampled : rx_byte_reg;
  assign rx_cat      = {rx_complete, rx_buf_reg};

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    phase_last = 1'b0;
    unique case (state_reg)
      S_IDLE: if (sndRec) state_next = S_LEAD;
      S_LEAD: begin
        phase_last = (hcnt_reg == HW'(SS_LEAD - 1));
        if (tick && phase_last) state_next = S_XFER;
      end
      S_XFER: begin
        phase_last = (hcnt_reg == HW'(15));
        if (tick && phase_last) begin
          if (byte_idx_reg == BW'(NBYTES - 1)) state_next = S_TRAIL;
          else if (BYTE_GAP > 0)               state_next = S_GAP;
        end
      end
      S_GAP: begin
        phase_last = (hcnt_reg == HW'(BYTE_GAP - 1));
        if (tick && phase_last) state_next = S_XFER;
      end
      S_TRAIL: begin
        phase_last = 1'b1;
        if (tick) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt_reg  <= '0;
      hcnt_reg     <= '0;
      byte_idx_reg <= '0;
      tx_rest_reg  <= '0;
      tx_byte_reg  <= '0;
      rx_byte_reg  <= '0;
      rx_buf_reg   <= '0;
      dout_reg     <= '0;
      ss_reg       <= 1'b1;
      sclk_reg     <= CPOL;
      mosi_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      if (state_reg == S_IDLE || state_reg == S_DONE || tick) div_cnt_reg <= '0;
      else                                                    div_cnt_reg <= div_cnt_reg + DW'(1);

      if (state_reg == S_IDLE || state_reg == S_DONE) hcnt_reg <= '0;
      else if (tick) hcnt_reg <= phase_last ? '0 : hcnt_reg + HW'(1);

      if (state_reg == S_IDLE) byte_idx_reg <= '0;
      else if (byte_end)       byte_idx_reg <= byte_idx_reg + BW'(1);

      if (state_reg == S_XFER && tick) sclk_reg <= ~sclk_reg;

      ss_reg   <= ~frame_next;
      busy_reg <= (state_next != S_IDLE);
      done_reg <= (state_next == S_DONE);
      if (state_next == S_DONE) dout_reg <= rx_buf_reg;

      // CPHA=0 keeps the bit under transmission on MOSI ahead of its sampling edge.
      if (accept) begin
        tx_rest_reg <= DIN >> 8;
        if (!CPHA) begin
          tx_byte_reg <= {DIN[6:0], 1'b0};
          mosi_reg    <= DIN[7];
        end else begin
          tx_byte_reg <= DIN[7:0];
          mosi_reg    <= 1'b0;
        end
      end else if (!frame_next) begin
        mosi_reg <= 1'b0;
      end else if (byte_end) begin
        tx_rest_reg <= tx_rest_reg >> 8;
        if (!CPHA) begin
          tx_byte_reg <= {tx_rest_reg[6:0], 1'b0};
          mosi_reg    <= tx_rest_reg[7];
        end else begin
          tx_byte_reg <= tx_rest_reg[7:0];
        end
      end else if (CPHA ? lead_edge : trail_edge) begin
        mosi_reg    <= tx_byte_reg[7];
        tx_byte_reg <= {tx_byte_reg[6:0], 1'b0};
      end

      if (accept) rx_byte_reg <= '0;
      else if (CPHA ? trail_edge : lead_edge) rx_byte_reg <= rx_sampled;

      // Completed bytes enter at the top so the first byte ends up in the low slot.
      if (byte_end) rx_buf_reg <= rx_cat[W+7:8];
    end
  end

  assign SS   = ss_reg;
  assign SCLK = sclk_reg;
  assign MOSI = mosi_reg;
  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign DOUT = dout_reg;

endmodule

// File: tb/tb_pmod_spi_master.sv
// Bench for pmod_spi_master: five instances (modes 0-3, and a two-byte one with inter-byte gap)
// driven against a bit-level SPI slave model and checked with immediate assertions.
module tb_pmod_spi_master;
  logic        clk;
  logic        rst;
  logic [4:0]  sndrec;
  logic [39:0] din;
  logic [47:0] resp;
  logic [4:0]  ss_v, sclk_v, mosi_v, busy_v, done_v;
  logic [39:0] dout_a [5];
  logic [47:0] cap_a  [5];
  int ncmp, nfail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    localparam bit CP = (gi == 2) || (gi == 3);
    localparam bit CH = (gi == 1) || (gi == 3);
    localparam int NB = (gi == 4) ? 2 : 5;
    localparam int GP = (gi == 4) ? 3 : 0;
    logic [8*NB-1:0] dout_l;
    logic [47:0]     cap_l;
    logic            ss_l, sclk_l, mosi_l, busy_l, done_l, miso_l, prev, act;
    int              s;

    pmod_spi_master #(.CLK_DIV(4), .NBYTES(NB), .CPOL(CP), .CPHA(CH),
                      .SS_LEAD(1), .BYTE_GAP(GP)) u_dut (
      .CLK(clk), .RST(rst), .sndRec(sndrec[gi]), .DIN(din[8*NB-1:0]), .MISO(miso_l),
      .SS(ss_l), .SCLK(sclk_l), .MOSI(mosi_l), .BUSY(busy_l), .DONE(done_l), .DOUT(dout_l));

    assign ss_v[gi]   = ss_l;
    assign sclk_v[gi] = sclk_l;
    assign mosi_v[gi] = mosi_l;
    assign busy_v[gi] = busy_l;
    assign done_v[gi] = done_l;
    assign dout_a[gi] = 40'(dout_l);
    assign cap_a[gi]  = cap_l;

    // Slave: samples MOSI on the mode's sample edge, changes MISO on the other edge,
    // bit s of the frame is bit 7-s%8 of byte s/8 in both directions.
    always @(negedge clk) begin
      if (ss_l) begin
        act    <= 1'b0;
        s      <= 0;
        miso_l <= 1'b0;
        prev   <= CP;
      end else begin
        prev <= sclk_l;
        if (!act) begin
          act   <= 1'b1;
          cap_l <= '0;
          if (!CH) miso_l <= resp[7];
        end else if (sclk_l != prev) begin
          if ((sclk_l != CP) != CH) begin
            cap_l[8*(s/8) + 7 - s%8] <= mosi_l;
            s <= s + 1;
          end else begin
            miso_l <= resp[8*(s/8) + 7 - s%8];
          end
        end
      end
    end
  end

  function automatic int nbytes_of(input int idx);
    return (idx == 4) ? 2 : 5;
  endfunction

  function automatic logic cpol_of(input int idx);
    return (idx == 2) || (idx == 3);
  endfunction

  // Cycles from the request negedge to the negedge where DONE is seen: T + 1.
  function automatic int lat(input int idx);
    int nb, gp;
    nb = nbytes_of(idx);
    gp = (idx == 4) ? 3 : 0;
    return 4 * (1 + 16*nb + gp*(nb-1) + 1) + 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: re-request and DIN change mid-transfer, 2: reset during byte 3
  task automatic run(input int idx, input int mode);
    logic [39:0] d0, r0, mask;
    int cyc, extra;
    bit got, ss_hi;
    mask = (nbytes_of(idx) == 5) ? 40'hFF_FFFF_FFFF : 40'h00_0000_FFFF;
    d0 = din & mask;
    r0 = resp[39:0] & mask;
    @(negedge clk); sndrec[idx] = 1'b1;
    @(negedge clk); sndrec[idx] = 1'b0;
    chk("accept_busy", 64'(busy_v[idx]), 64'(1));
    chk("accept_ss", 64'(ss_v[idx]), 64'(0));
    cyc = 1; got = 0; ss_hi = 0;
    while (!got && cyc < 3000) begin
      if (done_v[idx] === 1'b1) got = 1;
      else begin
        if (ss_v[idx] !== 1'b0) ss_hi = 1;
        if (mode == 1 && cyc == 100) begin sndrec[idx] = 1'b1; din = ~din; end
        if (mode == 1 && cyc == 101) sndrec[idx] = 1'b0;
        if (mode == 2 && cyc == 152) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk("rst_mid_ss", 64'(ss_v[idx]), 64'(1));
          chk("rst_mid_sclk", 64'(sclk_v[idx]), 64'(cpol_of(idx)));
          chk("rst_mid_busy", 64'(busy_v[idx]), 64'(0));
          chk("rst_mid_mosi", 64'(mosi_v[idx]), 64'(0));
          chk("rst_mid_dout", 64'(dout_a[idx]), 64'(0));
          return;
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", 64'(got), 64'(1));
    chk("latency", 64'(cyc), 64'(lat(idx)));
    chk("dout", 64'(dout_a[idx]), 64'(r0));
    chk("mosi_bytes", 64'(cap_a[idx][39:0]), 64'(d0));
    chk("ss_low_frame", 64'(ss_hi), 64'(0));
    chk("done_busy", 64'(busy_v[idx]), 64'(1));
    chk("done_ss", 64'(ss_v[idx]), 64'(1));
    chk("done_mosi", 64'(mosi_v[idx]), 64'(0));
    chk("sclk_idle", 64'(sclk_v[idx]), 64'(cpol_of(idx)));
    $display("xfer idx=%0d mode=%0d din=%h dout=%h cycles=%0d", idx, mode, d0, dout_a[idx], cyc);
    @(negedge clk);
    chk("done_pulse", 64'(done_v[idx]), 64'(0));
    chk("idle_busy", 64'(busy_v[idx]), 64'(0));
    if (mode == 1) begin
      extra = 0;
      repeat (20) begin
        @(negedge clk);
        if (done_v[idx] !== 1'b0 || busy_v[idx] !== 1'b0) extra++;
      end
      chk("no_queued_xfer", 64'(extra), 64'(0));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] ed, er;
    int n;
    ncmp = 0; nfail = 0;
    rst = 1'b1; sndrec = '0; din = '0; resp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("rst_ss", 64'(ss_v[i]), 64'(1));
      chk("rst_sclk", 64'(sclk_v[i]), 64'(cpol_of(i)));
      chk("rst_mosi", 64'(mosi_v[i]), 64'(0));
      chk("rst_busy", 64'(busy_v[i]), 64'(0));
      chk("rst_done", 64'(done_v[i]), 64'(0));
      chk("rst_dout", 64'(dout_a[i]), 64'(0));
    end
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      din = 40'h05_0403_0201; resp = 48'h00_A5A4_A3A2_A1;
      run(i, 0);
      repeat (2) begin
        din  = 40'({$urandom(), $urandom()});
        resp = 48'({$urandom(), $urandom()});
        run(i, 0);
      end
    end

    din = 40'({$urandom(), $urandom()}); resp = 48'({$urandom(), $urandom()});
    run(0, 1);

    din = 40'({$urandom(), $urandom()}); resp = 48'({$urandom(), $urandom()});
    run(3, 2);
    din = 40'({$urandom(), $urandom()}); resp = 48'({$urandom(), $urandom()});
    run(3, 0);

    din = 40'({$urandom(), $urandom()}); resp = 48'({$urandom(), $urandom()});
    ed = din; er = resp[39:0];
    @(negedge clk); sndrec[1] = 1'b1;
    n = 0;
    for (int t = 0; t < 3; t++) begin
      while (done_v[1] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      chk("b2b_period", 64'(n), 64'((t == 0) ? lat(1) : lat(1) + 1));
      chk("b2b_dout", 64'(dout_a[1]), 64'(er));
      chk("b2b_mosi", 64'(cap_a[1][39:0]), 64'(ed));
      $display("b2b xfer %0d din=%h dout=%h cycles=%0d", t, ed, dout_a[1], n);
      din = 40'({$urandom(), $urandom()}); resp = 48'({$urandom(), $urandom()});
      ed = din; er = resp[39:0];
      if (t == 2) sndrec[1] = 1'b0;
      @(negedge clk);
      n = 1;
      chk("b2b_ss_high", 64'(ss_v[1]), 64'(1));
      chk("b2b_single_done", 64'(done_v[1]), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
